// File: rtl/dpram_be_clr_if.sv
// Bus bundle for the dual-port byte-enable RAM: both access ports plus clear control.
// The master side drives requests; the slave side (the RAM) returns read data and status.
interface dpram_be_clr_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  clr_req;
    logic                  busy;
    logic                  collision;

    logic                  en_a;
    logic                  wen_a;
    logic [BE_WIDTH-1:0]   be_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic                  valid_a;

    logic                  en_b;
    logic                  wen_b;
    logic [BE_WIDTH-1:0]   be_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  valid_b;

    modport master (
        output clr_req,
        output en_a, wen_a, be_a, addr_a, data_a,
        output en_b, wen_b, be_b, addr_b, data_b,
        input  busy, collision,
        input  q_a, valid_a,
        input  q_b, valid_b
    );

    modport slave (
        input  clr_req,
        input  en_a, wen_a, be_a, addr_a, data_a,
        input  en_b, wen_b, be_b, addr_b, data_b,
        output busy, collision,
        output q_a, valid_a,
        output q_b, valid_b
    );
endinterface

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, 1- or 2-cycle read latency and a
// self-clearing sequencer that sweeps every word after reset or on request.
module dpram_be_clr #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    RD_LATENCY  = 1,
    parameter int                    RDW_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic           clk,
    input logic           rst,
    dpram_be_clr_if.slave bus
);
    localparam int                    BE_WIDTH  = DATA_WIDTH / 8;
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] clr_addr_next;
    logic                  busy;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_a;
    logic                  acc_b;
    logic                  wr_a;
    logic                  wr_b;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic [DATA_WIDTH-1:0] q1_a;
    logic [DATA_WIDTH-1:0] q1_b;
    logic                  v1_a;
    logic                  v1_b;
    logic                  collision;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) result[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return result;
    endfunction

    assign busy  = (state == CLEAR);
    assign acc_a = bus.en_a && !busy;
    assign acc_b = bus.en_b && !busy;
    assign wr_a  = acc_a && bus.wen_a;
    assign wr_b  = acc_b && bus.wen_b;

    // Reset lands in CLEAR so the array is always swept before first use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                clr_addr_next = clr_addr + 1'b1;
                if (clr_addr == LAST_ADDR) state_next = IDLE;
            end
            default: begin
                state_next    = CLEAR;
                clr_addr_next = '0;
            end
        endcase
    end

    // B is applied before A in each byte lane so A wins a same-address, same-byte clash.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_b && bus.be_b[i]) mem[bus.addr_b][i*8 +: 8] <= bus.data_b[i*8 +: 8];
                if (wr_a && bus.be_a[i]) mem[bus.addr_a][i*8 +: 8] <= bus.data_a[i*8 +: 8];
            end
        end
    end

    // Cross-port reads always see the old word; only a port's own write can be forwarded.
    always_comb begin
        rd_a = mem[bus.addr_a];
        rd_b = mem[bus.addr_b];
        if (RDW_MODE == 1 && bus.wen_a) rd_a = merge_bytes(mem[bus.addr_a], bus.data_a, bus.be_a);
        if (RDW_MODE == 1 && bus.wen_b) rd_b = merge_bytes(mem[bus.addr_b], bus.data_b, bus.be_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_a      <= 1'b0;
            v1_b      <= 1'b0;
            q1_a      <= '0;
            q1_b      <= '0;
            collision <= 1'b0;
        end else begin
            v1_a      <= acc_a;
            v1_b      <= acc_b;
            if (acc_a) q1_a <= rd_a;
            if (acc_b) q1_b <= rd_b;
            collision <= wr_a && wr_b && (bus.addr_a == bus.addr_b)
                         && (|bus.be_a) && (|bus.be_b);
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] q2_a;
            logic [DATA_WIDTH-1:0] q2_b;
            logic                  v2_a;
            logic                  v2_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                    q2_a <= '0;
                    q2_b <= '0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) q2_a <= q1_a;
                    if (v1_b) q2_b <= q1_b;
                end
            end

            assign bus.q_a     = q2_a;
            assign bus.q_b     = q2_b;
            assign bus.valid_a = v2_a;
            assign bus.valid_b = v2_b;
        end else begin : g_lat1
            assign bus.q_a     = q1_a;
            assign bus.q_b     = q1_b;
            assign bus.valid_a = v1_a;
            assign bus.valid_b = v1_b;
        end
    endgenerate

    assign bus.busy      = busy;
    assign bus.collision = collision;
endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: two instances (latency 1 / old-data and latency 2 / new-data)
// share one stimulus stream and are compared each cycle against a word-level model.
module tb_dpram_be_clr;
    localparam int              DW    = 64;
    localparam int              AW    = 6;
    localparam int              BW    = DW / 8;
    localparam int              DEPTH = 1 << AW;
    localparam logic [DW-1:0]   CLR_VAL = '0;
    localparam int              LAT0 = 1;
    localparam int              RDW0 = 0;
    localparam int              LAT1 = 2;
    localparam int              RDW1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dpram_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    dpram_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus1.clr_req = bus0.clr_req;
    assign bus1.en_a    = bus0.en_a;
    assign bus1.wen_a   = bus0.wen_a;
    assign bus1.be_a    = bus0.be_a;
    assign bus1.addr_a  = bus0.addr_a;
    assign bus1.data_a  = bus0.data_a;
    assign bus1.en_b    = bus0.en_b;
    assign bus1.wen_b   = bus0.wen_b;
    assign bus1.be_b    = bus0.be_b;
    assign bus1.addr_b  = bus0.addr_b;
    assign bus1.data_b  = bus0.data_b;

    dpram_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT0),
                   .RDW_MODE(RDW0), .CLEAR_VALUE(CLR_VAL))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    dpram_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT1),
                   .RDW_MODE(RDW1), .CLEAR_VALUE(CLR_VAL))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy;
    int            m_clr;
    bit            e_col;
    bit            e_valid [2][2];
    logic [DW-1:0] e_q     [2][2];
    bit            pend_v  [2][2];
    logic [DW-1:0] pend_q  [2][2];

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_word,
                                            input logic [DW-1:0] new_word,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_word;
        for (int i = 0; i < BW; i++) if (be[i]) r[i*8 +: 8] = new_word[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 1'b1;
        m_clr  = 0;
        e_col  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                e_valid[i][p] = 1'b0;
                e_q[i][p]     = '0;
                pend_v[i][p]  = 1'b0;
                pend_q[i][p]  = '0;
            end
        end
    endtask

    // One clock of the reference: accept, read old words, queue results by latency, then write.
    task automatic model_step();
        bit            en [2];
        bit            wen[2];
        bit            acc[2];
        logic [BW-1:0] be  [2];
        logic [AW-1:0] addr[2];
        logic [DW-1:0] data[2];
        logic [DW-1:0] old [2];
        logic [DW-1:0] nq;
        bit            out_v;
        logic [DW-1:0] out_q;
        en[0] = bus0.en_a;  wen[0] = bus0.wen_a;  be[0] = bus0.be_a;
        addr[0] = bus0.addr_a;  data[0] = bus0.data_a;
        en[1] = bus0.en_b;  wen[1] = bus0.wen_b;  be[1] = bus0.be_b;
        addr[1] = bus0.addr_b;  data[1] = bus0.data_b;
        for (int p = 0; p < 2; p++) begin
            acc[p] = en[p] && !m_busy;
            old[p] = m_mem[addr[p]];
        end
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                nq = (((i == 0) ? RDW0 : RDW1) == 1 && wen[p]) ? merge(old[p], data[p], be[p]) : old[p];
                if (((i == 0) ? LAT0 : LAT1) == 1) begin
                    out_v = acc[p];
                    out_q = nq;
                end else begin
                    out_v = pend_v[i][p];
                    out_q = pend_q[i][p];
                    pend_v[i][p] = acc[p];
                    pend_q[i][p] = nq;
                end
                e_valid[i][p] = out_v;
                if (out_v) e_q[i][p] = out_q;
            end
        end
        e_col = acc[0] && acc[1] && wen[0] && wen[1] && (addr[0] == addr[1])
                && (be[0] != 0) && (be[1] != 0);
        if (m_busy) begin
            m_mem[m_clr] = CLR_VAL;
            m_clr++;
            if (m_clr == DEPTH) begin
                m_busy = 1'b0;
                m_clr  = 0;
            end
        end else begin
            if (bus0.clr_req) begin
                m_busy = 1'b1;
                m_clr  = 0;
            end
            for (int p = 1; p >= 0; p--) begin
                if (acc[p] && wen[p]) m_mem[addr[p]] = merge(m_mem[addr[p]], data[p], be[p]);
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst === 1'b0) model_step();
    end

    always @(negedge clk) begin
        checkOutput("busy0",      64'(bus0.busy),      64'(m_busy));
        checkOutput("busy1",      64'(bus1.busy),      64'(m_busy));
        checkOutput("collision0", 64'(bus0.collision), 64'(e_col));
        checkOutput("collision1", 64'(bus1.collision), 64'(e_col));
        checkOutput("valid_a0",   64'(bus0.valid_a),   64'(e_valid[0][0]));
        checkOutput("valid_b0",   64'(bus0.valid_b),   64'(e_valid[0][1]));
        checkOutput("valid_a1",   64'(bus1.valid_a),   64'(e_valid[1][0]));
        checkOutput("valid_b1",   64'(bus1.valid_b),   64'(e_valid[1][1]));
        checkOutput("q_a0",       bus0.q_a,            e_q[0][0]);
        checkOutput("q_b0",       bus0.q_b,            e_q[0][1]);
        checkOutput("q_a1",       bus1.q_a,            e_q[1][0]);
        checkOutput("q_b1",       bus1.q_b,            e_q[1][1]);
    end

    task automatic idle_inputs();
        bus0.clr_req = 1'b0;
        bus0.en_a = 1'b0;  bus0.wen_a = 1'b0;  bus0.be_a = '0;  bus0.addr_a = '0;  bus0.data_a = '0;
        bus0.en_b = 1'b0;  bus0.wen_b = 1'b0;  bus0.be_b = '0;  bus0.addr_b = '0;  bus0.data_b = '0;
    endtask

    task automatic set_a(input bit en, input bit wen, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus0.en_a = en;  bus0.wen_a = wen;  bus0.be_a = be;  bus0.addr_a = addr;  bus0.data_a = data;
    endtask

    task automatic set_b(input bit en, input bit wen, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus0.en_b = en;  bus0.wen_b = wen;  bus0.be_b = be;  bus0.addr_b = addr;  bus0.data_b = data;
    endtask

    task automatic applyStimulus(input bit clr);
        bus0.clr_req = clr;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (bus0.busy === 1'b1 && n < 200) begin
            applyStimulus(1'b0);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int r;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        wait_clear(n);
        checkOutput("reset_busy_cycles", 64'(n), 64'd64);
        for (int a = 0; a < DEPTH; a++) begin
            set_a(1'b1, 1'b0, '0, 6'(a), '0);
            set_b(1'b1, 1'b0, '0, 6'(DEPTH - 1 - a), '0);
            applyStimulus(1'b0);
            checkOutput("cleared_q_a", bus0.q_a, 64'h0);
            checkOutput("cleared_valid_a", 64'(bus0.valid_a), 64'd1);
        end

        set_a(1'b1, 1'b1, 8'hFF, 6'd5, {8{8'h11}});
        applyStimulus(1'b0);
        set_a(1'b1, 1'b1, 8'h0F, 6'd5, {8{8'h22}});
        applyStimulus(1'b0);
        set_a(1'b1, 1'b0, '0, 6'd5, '0);
        applyStimulus(1'b0);
        checkOutput("be_merge_valid", 64'(bus0.valid_a), 64'd1);
        checkOutput("be_merge_q", bus0.q_a, 64'h1111111122222222);

        set_a(1'b1, 1'b1, 8'hF0, 6'd9, {8{8'hAA}});
        set_b(1'b1, 1'b1, 8'hFF, 6'd9, {8{8'hBB}});
        applyStimulus(1'b0);
        checkOutput("collision_pulse", 64'(bus0.collision), 64'd1);
        applyStimulus(1'b0);
        checkOutput("collision_drop", 64'(bus0.collision), 64'd0);
        set_a(1'b1, 1'b0, '0, 6'd9, '0);
        applyStimulus(1'b0);
        checkOutput("dual_write_word", bus0.q_a, 64'hAAAAAAAABBBBBBBB);

        set_a(1'b1, 1'b1, 8'hFF, 6'd3, 64'h5);
        applyStimulus(1'b0);
        set_a(1'b1, 1'b1, 8'hFF, 6'd3, 64'h7);
        set_b(1'b1, 1'b0, '0, 6'd3, '0);
        applyStimulus(1'b0);
        checkOutput("rdw_old_q_a", bus0.q_a, 64'h5);
        checkOutput("rdw_old_q_b", bus0.q_b, 64'h5);
        applyStimulus(1'b0);
        checkOutput("rdw_new_q_a", bus1.q_a, 64'h7);
        checkOutput("rdw_cross_q_b", bus1.q_b, 64'h5);

        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 1'b1, 8'hFF, 6'(10 + i), 64'h1000_0000_0000_00A0 + 64'(i));
            applyStimulus(1'b0);
        end
        repeat (2) applyStimulus(1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_a(1'b1, 1'b0, '0, 6'(10 + i), '0);
            applyStimulus(1'b0);
            checkOutput("lat2_valid", 64'(bus1.valid_a), (i >= 1 && i <= 4) ? 64'd1 : 64'd0);
            if (i >= 1 && i <= 4)
                checkOutput("lat2_q", bus1.q_a, 64'h1000_0000_0000_00A0 + 64'(i - 1));
        end

        set_a(1'b1, 1'b0, '0, 6'd5, '0);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("pending_valid", 64'(bus1.valid_a), 64'd1);
        checkOutput("pending_q", bus1.q_a, 64'h1111111122222222);
        checkOutput("clr_busy", 64'(bus0.busy), 64'd1);
        set_a(1'b1, 1'b1, 8'hFF, 6'd20, 64'hDEAD_BEEF_0000_0001);
        set_b(1'b1, 1'b0, '0, 6'd5, '0);
        applyStimulus(1'b1);
        checkOutput("busy_drop_a", 64'(bus0.valid_a), 64'd0);
        checkOutput("busy_drop_b", 64'(bus0.valid_b), 64'd0);
        repeat (20) applyStimulus(1'b0);
        do_reset();
        wait_clear(n);
        checkOutput("restart_busy_cycles", 64'(n), 64'd64);
        set_a(1'b1, 1'b0, '0, 6'd20, '0);
        set_b(1'b1, 1'b0, '0, 6'd5, '0);
        applyStimulus(1'b0);
        checkOutput("post_clear_q_a", bus0.q_a, 64'h0);
        checkOutput("post_clear_q_b", bus0.q_b, 64'h0);

        for (int c = 0; c < 2500; c++) begin
            r = $urandom_range(0, 999);
            if (r < 4) begin
                do_reset();
            end else begin
                set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
                      {$urandom, $urandom});
                set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
                      {$urandom, $urandom});
                applyStimulus(r < 10);
            end
        end
        repeat (4) applyStimulus(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dpram_be_clr.md
DPRAM_BE_CLR -- requirements
Module: dpram_be_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, word width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, giving a depth of 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter RDW_MODE, default 0, same-port read-during-write: 0 returns old data, 1 returns new (merged) data.
REQ-005 SHALL have parameter CLEAR_VALUE, default 0, the DATA_WIDTH word written by the clear sequence.
REQ-006 SHALL have ports: clk input 1 (clock); rst input 1 (asynchronous, active-high reset).
REQ-007 SHALL have ports: clr_req input 1 (clear request pulse); busy output 1 (clear in progress).
REQ-008 SHALL have, per port x in {a,b}: en_x input 1 (access enable); wen_x input 1 (write); be_x input DATA_WIDTH/8 (byte enables); addr_x input ADDR_WIDTH; data_x input DATA_WIDTH.
REQ-009 SHALL have, per port x in {a,b}: q_x output DATA_WIDTH (read data); valid_x output 1 (q_x is valid).
REQ-010 SHALL have collision output 1: same-address dual-write flag.

Function
REQ-011 SHALL implement the memory as one shared 2^ADDR_WIDTH x DATA_WIDTH array with two independent read/write ports on clk.
REQ-012 SHALL accept an access on port x when en_x=1 and busy=0; accesses presented while busy=1 are dropped with no write and no valid.
REQ-013 SHALL, on an accepted write, update only the bytes whose be_x bit is 1; be_x=0 leaves the word unchanged, but the access still produces valid_x.
REQ-014 SHALL assert valid_x exactly RD_LATENCY cycles after every accepted access (read or write), with q_x holding the word read at acceptance; q_x holds its value while valid_x=0.
REQ-015 SHALL pipeline q_x and valid_x, at RD_LATENCY=2, through one extra register stage; back-to-back accesses yield back-to-back valids.
REQ-016 SHALL, for a same-port write, return on q_x the pre-write word when RDW_MODE=0 and the byte-merged post-write word when RDW_MODE=1.
REQ-017 SHALL, when one port reads an address the other port writes in the same cycle, return the pre-write word regardless of RDW_MODE.
REQ-018 SHALL, when both ports write the same address in the same cycle, give port A priority on bytes enabled on both ports and take port-B-only bytes from B.
REQ-019 SHALL assert collision for one cycle, one cycle after a same-address dual write in which both be vectors are non-zero.
REQ-020 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-021 SHALL go from IDLE to CLEAR on clr_req=1.
REQ-022 SHALL, in CLEAR, write CLEAR_VALUE to address clr_addr each cycle starting from 0, and return to IDLE after address 2^ADDR_WIDTH-1, taking exactly 2^ADDR_WIDTH cycles.
REQ-023 SHALL drive busy=1 exactly while the FSM is in CLEAR.
REQ-024 SHALL ignore clr_req while in CLEAR, and SHALL let the clear complete the cycle on which busy falls, with no restart.
REQ-025 SHALL still deliver valids for accesses accepted before busy rose, as normal pipeline outputs.

Reset
REQ-026 SHALL, on rst=1 and asynchronously, force FSM=CLEAR, clr_addr=0, busy=1, q_a=q_b=0, valid_a=valid_b=0, collision=0, and flush all pipeline stages.
REQ-027 SHALL, after rst deasserts, run the full clear sequence before accepting accesses.
REQ-028 SHALL, on a reset asserted mid-clear or mid-access, discard all in-flight reads, and restart the clear from address 0 after deassert.

Verification
REQ-029 Reset scenario: defaults, release rst, count busy cycles -> busy=1 for exactly 64 cycles; then a read of every address -> 0.
REQ-030 Byte-enable scenario: write A addr 5 data 0x1111..11 be 0xFF, then write A addr 5 data 0x2222..22 be 0x0F, then read -> q_a=0x1111111122222222, with valid_a 1 cycle after the read.
REQ-031 Dual-write collision scenario: same cycle, A writes addr 9 0xAA..AA be 0xF0 and B writes addr 9 0xBB..BB be 0xFF -> word=0xAAAAAAAABBBBBBBB and a one-cycle collision pulse next cycle.
REQ-032 Read-during-write scenario: addr 3 holds 0x5, A writes 0x7 to addr 3 while B reads addr 3 -> q_b=0x5 in both modes; q_a=0x5 with RDW_MODE=0 and 0x7 with RDW_MODE=1.
REQ-033 Latency scenario: RD_LATENCY=2, 4 consecutive reads -> valid_a high for cycles 2..5 with data in order.
REQ-034 Clear-under-load scenario: clr_req while a read is pending and during busy, then rst pulse mid-clear -> the pending read still gets valid, accesses during busy are dropped, the clear restarts at 0, and busy lasts 64 cycles after reset release.
